// File: rtl/backend_cfg_pkg.sv
// Shared definitions for the backend configuration sequencer.
// State encodings, frame default and a counter-width helper.
package backend_cfg_pkg;

  localparam int unsigned FRAME_BITS_DEF = 5;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RST_LOW    = 3'd1,
    SHIFT      = 3'd2,
    WAIT_READY = 3'd3,
    DONE       = 3'd4,
    ERROR      = 3'd5
  } state_e;

  // Width of a counter that must reach n-1; never narrower than 1 bit.
  function automatic int unsigned cw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/backend_cfg_sequencer_serializer.sv
// Serial frame shifter: LSB first, sclk low then high per bit.
// sdin moves only when sclk falls or on the load cycle.
module bcs_serializer
  import backend_cfg_pkg::*;
#(
  parameter int unsigned SCLK_HALF  = 4,
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  sclk,
  output logic                  sdin,
  output logic                  last_bit_done
);

  localparam int unsigned HW = cw(SCLK_HALF);
  localparam int unsigned BW = cw(FRAME_BITS);
  localparam logic [HW-1:0] H_LAST = HW'(SCLK_HALF - 1);
  localparam logic [BW-1:0] B_LAST = BW'(FRAME_BITS - 1);

  logic                  active;
  logic [HW-1:0]         hcnt;
  logic [BW-1:0]         bcnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  half_end;

  assign half_end      = active && (hcnt == H_LAST);
  assign last_bit_done = half_end && sclk && (bcnt == B_LAST);

  // Half-period timing, bit counting and shifting of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      hcnt   <= '0;
      bcnt   <= '0;
      shreg  <= '0;
      sclk   <= 1'b0;
      sdin   <= 1'b0;
    end else if (load) begin
      active <= 1'b1;
      hcnt   <= '0;
      bcnt   <= '0;
      shreg  <= frame;
      sclk   <= 1'b0;
      sdin   <= frame[0];
    end else if (active) begin
      if (!half_end) begin
        hcnt <= hcnt + 1'b1;
      end else begin
        hcnt <= '0;
        sclk <= ~sclk;
        if (sclk) begin
          if (bcnt == B_LAST) begin
            active <= 1'b0;
            sdin   <= 1'b0;
          end else begin
            bcnt  <= bcnt + 1'b1;
            sdin  <= shreg[1];
            shreg <= shreg >> 1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/backend_cfg_sequencer.sv
// Backend start-up controller: reset, serial config load, ready wait.
// Optional BCS_AUTO_RETRY_EN replays the frame after a ready timeout.
module backend_cfg_sequencer
  import backend_cfg_pkg::*;
#(
  parameter int unsigned SCLK_HALF      = 4,
  parameter int unsigned FRAME_BITS     = FRAME_BITS_DEF,
  parameter int unsigned RST_LOW_CYCLES = 4,
  parameter int unsigned READY_TIMEOUT  = 1024,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [FRAME_BITS-1:0] i_cfg_data,
  input  logic                  i_ready,
  output logic                  o_resetbAll,
  output logic                  o_sclk,
  output logic                  o_sdin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int unsigned RW = cw(RST_LOW_CYCLES);
  localparam int unsigned TW = cw(READY_TIMEOUT);
  localparam logic [RW-1:0] R_LAST = RW'(RST_LOW_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(READY_TIMEOUT - 1);

  state_e                state;
  state_e                next;
  logic [FRAME_BITS-1:0] frame;
  logic [RW-1:0]         rcnt;
  logic [TW-1:0]         tcnt;
  logic                  accept;
  logic                  rst_last;
  logic                  timeout;
  logic                  load;
  logic                  last_bit_done;
  logic                  retry_ok;
  logic                  resetb_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  error_d;

  assign accept   = i_start &&
                    (state == IDLE || state == DONE || state == ERROR);
  assign rst_last = (rcnt == R_LAST);
  assign timeout  = (tcnt == T_LAST);
  assign load     = (state == RST_LOW) && rst_last;

`ifdef BCS_AUTO_RETRY_EN
  localparam int unsigned QW = cw(MAX_RETRY + 1);
  localparam logic [QW-1:0] Q_MAX = QW'(MAX_RETRY);

  logic [QW-1:0] retry;

  assign retry_ok = (retry < Q_MAX);

  // Retry count: cleared per request, bumped on each replayed attempt.
  always_ff @(posedge i_clk) begin
    if (i_rst || accept) begin
      retry <= '0;
    end else if (state == WAIT_READY && !i_ready &&
                 timeout && retry_ok) begin
      retry <= retry + 1'b1;
    end
  end
`else
  logic unused_retry;

  assign retry_ok     = 1'b0;
  assign unused_retry = (MAX_RETRY != 0);
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // Next-state decode.
  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (i_start) next = RST_LOW;
      end
      RST_LOW: begin
        if (rst_last) next = SHIFT;
      end
      SHIFT: begin
        if (last_bit_done) next = WAIT_READY;
      end
      WAIT_READY: begin
        if (i_ready) begin
          next = DONE;
        end else if (timeout) begin
          next = retry_ok ? RST_LOW : ERROR;
        end
      end
      DONE: begin
        if (i_start) begin
          next = RST_LOW;
        end else if (!i_ready) begin
          next = ERROR;
        end
      end
      ERROR: begin
        if (i_start) next = RST_LOW;
      end
      default: next = IDLE;
    endcase
  end

  // Output decode from the upcoming state so outputs can be registered.
  always_comb begin
    resetb_d = (next == SHIFT) || (next == WAIT_READY) ||
               (next == DONE);
    busy_d   = (next == RST_LOW) || (next == SHIFT) ||
               (next == WAIT_READY);
    done_d   = (next == DONE);
    error_d  = (next == ERROR);
  end

  // Registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_resetbAll <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      o_resetbAll <= resetb_d;
      o_busy      <= busy_d;
      o_done      <= done_d;
      o_error     <= error_d;
    end
  end

  // Reset-hold and ready-timeout counters, cleared on state entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rcnt <= '0;
      tcnt <= '0;
    end else begin
      rcnt <= (state == RST_LOW && next == RST_LOW) ?
              rcnt + 1'b1 : '0;
      tcnt <= (state == WAIT_READY && next == WAIT_READY) ?
              tcnt + 1'b1 : '0;
    end
  end

  // Frame capture on accepted start only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame <= '0;
    end else if (accept) begin
      frame <= i_cfg_data;
    end
  end

  bcs_serializer #(
    .SCLK_HALF  (SCLK_HALF),
    .FRAME_BITS (FRAME_BITS)
  ) u_ser (
    .clk           (i_clk),
    .rst           (i_rst),
    .load          (load),
    .frame         (frame),
    .sclk          (o_sclk),
    .sdin          (o_sdin),
    .last_bit_done (last_bit_done)
  );

endmodule

// File: tb/tb_backend_cfg_sequencer.sv
// Bench for backend_cfg_sequencer: scoreboarded serial frames,
// reset, timeout or retry, ignored start, mid reset, lost ready.
module tb_backend_cfg_sequencer;

  localparam int SH = 4;
  localparam int FB = 5;
  localparam int RL = 4;
  localparam int TO = 1024;
  localparam int MR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic [FB-1:0] cfg = '0;
  logic          resetb;
  logic          sclk;
  logic          sdin;
  logic          busy;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rises = 0;
  bit err_seen = 1'b0;
  logic exp_q[$];
  logic exp_bit;
  logic sclk_q = 1'b0;

  always #5 clk = ~clk;

  backend_cfg_sequencer #(
    .SCLK_HALF      (SH),
    .FRAME_BITS     (FB),
    .RST_LOW_CYCLES (RL),
    .READY_TIMEOUT  (TO),
    .MAX_RETRY      (MR)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_cfg_data  (cfg),
    .i_ready     (ready),
    .o_resetbAll (resetb),
    .o_sclk      (sclk),
    .o_sdin      (sdin),
    .o_busy      (busy),
    .o_done      (done),
    .o_error     (error)
  );

  // Scoreboard: every sclk rise pops one expected data bit.
  always @(negedge clk) begin
    if (error) err_seen = 1'b1;
    if (sclk && !sclk_q) begin
      rises++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sdin_extra_rise: rise %0d with sdin=%b, required no rise",
                 rises, sdin);
      end else begin
        exp_bit = exp_q.pop_front();
        if (sdin !== exp_bit) begin
          errors++;
          $display("FAIL sdin_bit: rise %0d got %b, required %b",
                   rises, sdin, exp_bit);
        end
      end
    end
    sclk_q = sclk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    cfg   = '0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    rises    = 0;
    err_seen = 1'b0;
  endtask

  task automatic push_frame(input logic [FB-1:0] f);
    for (int i = 0; i < FB; i++) exp_q.push_back(f[i]);
  endtask

  task automatic send(input logic [FB-1:0] f);
    cfg   = f;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_frame_end(input int target, input int limit);
    int n;
    n = 0;
    while (!(rises >= target && !sclk) && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL frame_end_wait: rises %0d after %0d cycles, required %0d",
               rises, n, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({resetb, sclk, sdin, busy, done, error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 000000",
               {resetb, sclk, sdin, busy, done, error});
    end
    do_reset();
  endtask

  task automatic test_basic();
    int t0;
    int t_acc;
    int n;
    do_reset();
    push_frame(5'b10110);
    t0 = cyc;
    send(5'b10110);
    t_acc = cyc;
    n = 0;
    while (!resetb && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n != RL) begin
      errors++;
      $display("FAIL resetb_low_len: got %0d, required %0d", n, RL);
    end
    while (!sclk && (cyc - t0) < 100) tick();
    checks++;
    if ((cyc - t0) != RL + SH + 1) begin
      errors++;
      $display("FAIL first_rise_latency: got %0d, required %0d",
               cyc - t0, RL + SH + 1);
    end
    wait_frame_end(FB, 200);
    checks++;
    if ((cyc - t_acc) != RL + 2 * SH * FB) begin
      errors++;
      $display("FAIL wait_ready_latency: got %0d, required %0d",
               cyc - t_acc, RL + 2 * SH * FB);
    end
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL waiting_status: busy,done got %b, required 10",
               {busy, done});
    end
    ready = 1'b1;
    tick();
    checks++;
    if ({resetb, busy, done, error} !== 4'b1010) begin
      errors++;
      $display("FAIL done_status: got %b, required 1010",
               {resetb, busy, done, error});
    end
    checks++;
    if (rises != FB || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_frame_count: rises %0d left %0d, required %0d and 0",
               rises, exp_q.size(), FB);
    end
  endtask

`ifdef BCS_AUTO_RETRY_EN
  task automatic test_retry();
    do_reset();
    for (int a = 0; a < 3; a++) push_frame(5'b10011);
    send(5'b10011);
    wait_frame_end(FB, 200);
    wait_frame_end(2 * FB, TO + 200);
    wait_frame_end(3 * FB, TO + 200);
    tick();
    tick();
    ready = 1'b1;
    tick();
    checks++;
    if ({done, error} !== 2'b10) begin
      errors++;
      $display("FAIL retry_done: done,error got %b, required 10",
               {done, error});
    end
    checks++;
    if (err_seen || rises != 3 * FB || exp_q.size() != 0) begin
      errors++;
      $display("FAIL retry_frames: err_seen %0d rises %0d left %0d, required 0 %0d 0",
               err_seen, rises, exp_q.size(), 3 * FB);
    end
  endtask
`else
  task automatic test_timeout();
    int m;
    do_reset();
    push_frame(5'b01011);
    send(5'b01011);
    wait_frame_end(FB, 200);
    m = 0;
    while (!error && m < TO + 20) begin
      tick();
      m++;
    end
    checks++;
    if (m != TO) begin
      errors++;
      $display("FAIL timeout_len: got %0d, required %0d", m, TO);
    end
    checks++;
    if ({resetb, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_status: resetb,busy,done got %b, required 000",
               {resetb, busy, done});
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (error !== 1'b1 || rises != FB) begin
      errors++;
      $display("FAIL error_sticky: error %b rises %0d, required 1 and %0d",
               error, rises, FB);
    end
  endtask
`endif

  task automatic test_start_ignored();
    int n;
    do_reset();
    push_frame(5'b01101);
    send(5'b01101);
    n = 0;
    while (rises < 2 && n < 100) begin
      tick();
      n++;
    end
    cfg   = 5'b10010;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, resetb} !== 2'b11) begin
      errors++;
      $display("FAIL start_ignored_status: busy,resetb got %b, required 11",
               {busy, resetb});
    end
    wait_frame_end(FB, 200);
    checks++;
    if (rises != FB || exp_q.size() != 0) begin
      errors++;
      $display("FAIL start_ignored_frame: rises %0d left %0d, required %0d and 0",
               rises, exp_q.size(), FB);
    end
    ready = 1'b1;
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored_done: got %b, required 1", done);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    do_reset();
    push_frame(5'b11001);
    send(5'b11001);
    n = 0;
    while (!(rises >= 2 && !sclk) && n < 100) begin
      tick();
      n++;
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({resetb, sclk, sdin, busy, done, error} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b, required 000000",
               {resetb, sclk, sdin, busy, done, error});
    end
    exp_q.delete();
    rises = 0;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (rises != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle: rises %0d busy %b, required 0 and 0",
               rises, busy);
    end
    push_frame(5'b00111);
    send(5'b00111);
    wait_frame_end(FB, 200);
    checks++;
    if (rises != FB || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_frame: rises %0d left %0d, required %0d and 0",
               rises, exp_q.size(), FB);
    end
    ready = 1'b1;
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_done: got %b, required 1", done);
    end
  endtask

  task automatic test_lost_ready();
    ready = 1'b0;
    tick();
    checks++;
    if ({resetb, done, error} !== 3'b001) begin
      errors++;
      $display("FAIL lost_ready: resetb,done,error got %b, required 001",
               {resetb, done, error});
    end
    ready = 1'b1;
    tick();
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL lost_ready_sticky: got %b, required 1", error);
    end
    rises = 0;
    push_frame(5'b10101);
    send(5'b10101);
    checks++;
    if ({busy, error} !== 2'b10) begin
      errors++;
      $display("FAIL restart_clear: busy,error got %b, required 10",
               {busy, error});
    end
    wait_frame_end(FB, 200);
    tick();
    checks++;
    if ({done, error} !== 2'b10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_done: done,error got %b left %0d, required 10 and 0",
               {done, error}, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef BCS_AUTO_RETRY_EN
    test_retry();
`else
    test_timeout();
`endif
    test_start_ignored();
    test_mid_reset();
    test_lost_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
